// File: rtl/data_mem_responder.sv
// Data memory responder: latches a rd/wr strobe, waits WAIT_CYC cycles, performs the access and pulses mem_rdy.
// Optional address range checking is enabled by defining MEM_RANGE_CHK_EN.
module data_mem_responder #(
  parameter int MEM_AW   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        mem_rdy,
  output logic        mem_busy,
  output logic        mem_err,
  output logic [1:0]  mstate
);

  // Handshake: a strobe (mem_rd/mem_wr) seen in IDLE is captured; mem_rdy pulses for
  // exactly one cycle when the access is done; the requester must drop its strobe then.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_is_wr;
  logic [15:0] r_rdata;
  logic [15:0] r_mem [0:(1<<MEM_AW)-1];

  logic              w_req;
  logic              w_do_acc;
  logic              w_acc_wr;
  logic [15:0]       w_acc_addr;
  logic [15:0]       w_acc_wdata;
  logic [MEM_AW-1:0] w_idx;
  logic              w_oor;

  assign w_req = mem_rd | mem_wr;

  // With zero wait states the access happens on the capture edge, so live inputs are used.
  assign w_do_acc    = ((r_state == S_IDLE) && w_req && (WAIT_CYC == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_acc_wr    = (r_state == S_IDLE) ? mem_wr : r_is_wr;
  assign w_acc_addr  = (r_state == S_IDLE) ? addr   : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? wdata  : r_wdata;
  assign w_idx       = w_acc_addr[MEM_AW-1:0];

`ifdef MEM_RANGE_CHK_EN
  logic r_err;

  assign w_oor = |w_acc_addr[15:MEM_AW];

  // Error flag reflects the range status of the most recently completed access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_do_acc) begin
      r_err <= w_oor;
    end
  end

  assign mem_err = r_err;
`else
  logic w_unused_addr_hi;

  assign w_oor            = 1'b0;
  assign w_unused_addr_hi = ^w_acc_addr[15:MEM_AW];
  assign mem_err          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_is_wr <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_is_wr <= mem_wr;
            r_cnt   <= 4'(WAIT_CYC);
            r_state <= (WAIT_CYC == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_do_acc && !w_acc_wr) begin
        r_rdata <= w_oor ? 16'h0000 : r_mem[w_idx];
      end
    end
  end

  // RAM contents are not reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && w_do_acc && w_acc_wr && !w_oor) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  assign rdata    = r_rdata;
  assign mem_rdy  = (r_state == S_RESP);
  assign mem_busy = (r_state != S_IDLE);
  assign mstate   = r_state;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Single-port 16-bit data memory responder that services the `mem_rd` and `mem_wr` strobes issued by the processor control unit during LOAD/STORE execution. It latches the request, inserts a parameterised number of wait states, then performs the access and pulses `mem_rdy` for one cycle so the control unit can leave its memory state. It sits between the control unit/datapath and the on-chip data RAM.

## Interface
- `MEM_AW`, 8: internal RAM address width; depth = 2^MEM_AW words of 16 bits.
- `WAIT_CYC`, 1: wait states inserted between request capture and response (0–15).
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the idle state immediately.
- `mem_rd` in 1: read request strobe from the control unit.
- `mem_wr` in 1: write request strobe from the control unit.
- `addr` in 16: word address from the datapath.
- `wdata` in 16: write data from the datapath.
- `rdata` out 16: read data; valid while `mem_rdy`=1 on a read, then held.
- `mem_rdy` out 1: one-cycle completion pulse.
- `mem_busy` out 1: 1 whenever state ≠ IDLE.
- `mem_err` out 1: address-range error flag (see Configuration).
- `mstate` out 2: current state encoding for debug (IDLE=0, WAIT=1, RESP=2).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if `mem_wr` or `mem_rd` is 1 at a rising edge, latch `addr`, `wdata` and the request type. Load the wait counter with `WAIT_CYC`. Go to WAIT, or go directly to RESP if `WAIT_CYC`=0.
- If `mem_wr` and `mem_rd` are both 1, the request is treated as a write.
- WAIT: decrement the counter each cycle. On the edge where the counter reaches 1, go to RESP.
- Entry into RESP, on a single edge:
  - Write: commit latched `wdata` to RAM at latched `addr[MEM_AW-1:0]`.
  - Read: load `rdata` from RAM at the latched address.
  - Set `mem_rdy`=1.
- RESP: lasts exactly one cycle, then returns to IDLE unconditionally. Strobes present during RESP are ignored. The requester must deassert its strobe in the `mem_rdy` cycle, or a new request is captured in IDLE.
- Strobes and inputs that change during WAIT have no effect; the latched values are used.
- `rdata` holds its last read value across writes and idle cycles.
- Reset values: state IDLE, counter 0, `mem_rdy`=0, `mem_busy`=0, `mem_err`=0, `rdata`=0x0000, `mstate`=0.
- RAM contents are not reset.
- Reset during WAIT or RESP aborts the access. A write still in WAIT is not committed.

## Timing
- Request sampled at edge E0. `mem_rdy` is high for the cycle after edge E0+WAIT_CYC.
- Latency therefore equals WAIT_CYC+1 cycles.
- Back-to-back throughput: one access per WAIT_CYC+2 cycles, since IDLE needs at least one cycle to sample.
- `mem_busy` rises in the cycle after E0 and falls with `mem_rdy`.
- Read-after-write to the same address returns the new data, because the write commits before the next request is sampled.

## Configuration
- Macro `MEM_RANGE_CHK_EN`.
- Defined:
  - A request with `addr[15:MEM_AW]` ≠ 0 is still sequenced normally through WAIT/RESP.
  - Out-of-range write: RAM is not modified.
  - Out-of-range read: `rdata` loads 0x0000.
  - `mem_err` goes to 1 together with `mem_rdy` and stays high until the next in-range access completes, or until reset.
- Undefined:
  - Upper address bits are ignored and accesses alias modulo 2^MEM_AW.
  - `mem_err` is tied to 0.

## Test plan
- Reset, then write 0xBEEF to address 0x0012 with WAIT_CYC=1 -> `mem_rdy` high 2 cycles after the sampling edge, `mem_busy` high for 2 cycles. Then read 0x0012 -> `rdata`=0xBEEF with `mem_rdy`.
- WAIT_CYC=0: read immediately following a write to 0x0003 of 0x1234 -> each `mem_rdy` 1 cycle after its sampling edge, read returns 0x1234.
- Strobes held high through RESP -> a second access starts only in the following IDLE cycle, never during RESP.
- `mem_rd`=`mem_wr`=1, `addr`=0x0040, `wdata`=0x00AA -> treated as a write. A subsequent read of 0x0040 returns 0x00AA.
- Assert `reset` during WAIT of a write of 0x5555 to 0x0007 (address previously holding 0x1111) -> outputs return to reset values asynchronously. A later read of 0x0007 returns 0x1111.
- With `MEM_RANGE_CHK_EN`: write to 0x0112 -> `mem_err`=1, address 0x0012 unchanged. Next in-range read clears `mem_err`. Without the macro, the same write updates address 0x0012.
